benes_pipe_network: RTL and testbench
=====================================

// Module: benes_pipe_network
// PURPOSE
//  Parametrised, fully pipelined N-port Benes permutation network with valid/ready flow control.
//  Switch settings are double-buffered and travel with each beat, so a reconfiguration never
//  corrupts beats already in flight. It sits between the FHE ALU lanes and the buffer RAMs.
//  It is the successor to the fixed-size, free-running, unconfigurable-timing network.
// PARAMETERS
//  N_PORTS     8    number of ports; power of 2, >= 4
//  DATA_WIDTH  64   bits per port
//  LOG2N       $clog2(N_PORTS) (derived)
//  STAGES      2*LOG2N-1 (derived); number of switch stages, equal to latency in cycles
//  SW_NUM      N_PORTS/2 (derived); 2x2 switches per stage
// PORTS
//  clk        in   1                      clock, rising edge
//  rst_n      in   1                      synchronous active-low reset
//  in_valid   in   1                      input beat valid
//  in_ready   out  1                      network can accept a beat
//  in_data    in   DATA_WIDTH x N_PORTS   unpacked array [0:N_PORTS-1]
//  out_valid  out  1                      output beat valid
//  out_ready  in   1                      downstream accepts the beat
//  out_data   out  DATA_WIDTH x N_PORTS   unpacked array [0:N_PORTS-1]
//  cfg_we     in   1                      write one stage of the shadow config
//  cfg_stage  in   $clog2(STAGES)         stage index for cfg_we
//  cfg_bits   in   SW_NUM                 bit j controls switch j: 0 = straight, 1 = cross
//  cfg_commit in   1                      copy the shadow bank into the active bank
// BEHAVIOUR
//  - Reset: all valid flags are 0, out_data is 0, and the shadow and active banks are all 0.
//    All-straight routing is the identity permutation. After reset in_ready = 1.
//  - Switch j of a stage takes ports 2j and 2j+1. Straight passes each port to itself; cross swaps the pair.
//  - Link after stage s feeds stage s+1. For s < LOG2N-1, use block size B = N>>s (unshuffle):
//    local q -> (q>>1) + (q&1)*B/2.
//    For s >= LOG2N-1, use B = N>>(2*LOG2N-3-s) (shuffle): local q < B/2 -> 2q, otherwise 2(q-B/2)+1.
//  - Each stage output is registered, so latency is exactly STAGES accepted-advance cycles.
//  - advance = !out_valid || out_ready, and in_ready = advance. When advance is 0, the whole pipe holds.
//    Bubbles are not squeezed out. A beat is accepted when in_valid && in_ready.
//  - On accept, the beat captures a snapshot of the active bank. The register after stage k keeps
//    only the config for stages k+1..STAGES-1. Routing at stage k uses the beat's own snapshot.
//  - cfg_we with cfg_stage >= STAGES is ignored. cfg writes are allowed at any time, including during a stall.
//  - cfg_commit copies the shadow bank into the active bank at the clock edge. It includes a cfg_we
//    on the same cycle (write-through). A beat accepted in the same cycle as the commit uses the old
//    active bank. Beats accepted from the next cycle on use the new bank.
//  - Commit during a stall is legal. A stalled beat keeps its captured snapshot.
//  - rst_n low mid-stream: in-flight beats are dropped and the banks return to identity
//    in the next cycle. No partial beat appears.
//  - Data registers load only when advance = 1 and their upstream valid = 1. out_data holds while out_valid && !out_ready.
// TESTING (N_PORTS=8, DATA_WIDTH=16, STAGES=5)
//  1. Reset, then drive in_data[i]=16'h0A00+i with one valid beat. out_valid rises 5 cycles later
//     and out_data[i]=16'h0A00+i (identity).
//  2. cfg_we stage 0 = 4'hF, commit, then send in[i]=i. Expect out = {1,0,3,2,5,4,7,6}.
//     Repeat with only stage 4 = 4'hF and expect the same result.
//  3. Stream 8 beats and drop out_ready for 3 cycles mid-stream. in_ready is low for exactly those
//     cycles, all 8 beats arrive in order, and out_data is stable while stalled.
//  4. Send beats A and B with the identity config. Pulse cfg_commit (stage 0 = 4'hF) in the same
//     cycle as B. Send C next. A and B come out identity and C comes out pair-swapped.
//  5. With 3 beats in flight, hold rst_n low for 1 cycle. out_valid = 0 from the next cycle, and a
//     new beat routes as identity.
//  6. Send 500 random permutations with Benes routing computed by the bench model (looping algorithm)
//     and random out_ready. Every output beat must equal the model's permutation of its input.

Source files
------------

// File: rtl/benes_pipe_network.sv
// Fully pipelined N-port Benes permutation network with valid/ready flow control.
// Switch settings are double-buffered, and each beat carries its own copy of them down the pipe.
module benes_pipe_network #(
    parameter int N_PORTS    = 8,
    parameter int DATA_WIDTH = 64,
    localparam int LOG2N     = $clog2(N_PORTS),
    localparam int STAGES    = 2 * LOG2N - 1,
    localparam int SW_NUM    = N_PORTS / 2,
    localparam int STAGE_W   = $clog2(STAGES)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data [0:N_PORTS-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data [0:N_PORTS-1],
    input  logic                  cfg_we,
    input  logic [STAGE_W-1:0]    cfg_stage,
    input  logic [SW_NUM-1:0]     cfg_bits,
    input  logic                  cfg_commit
);

    // Destination position of link output p after stage s: unshuffle on the way in, shuffle on the way out.
    function automatic int link_dst(input int s, input int p);
        int blk;
        int q;
        int base;
        if (s < LOG2N - 1) blk = N_PORTS >> s;
        else               blk = N_PORTS >> (2 * LOG2N - 3 - s);
        q    = p % blk;
        base = p - q;
        if (s < LOG2N - 1)   return base + (q >> 1) + (q & 1) * (blk / 2);
        else if (q < blk / 2) return base + 2 * q;
        else                 return base + 2 * (q - blk / 2) + 1;
    endfunction

    logic [STAGES-1:0][SW_NUM-1:0] shadow_bank;
    logic [STAGES-1:0][SW_NUM-1:0] shadow_nxt;
    logic [STAGES-1:0][SW_NUM-1:0] active_bank;

    logic [DATA_WIDTH-1:0] st_in  [STAGES][N_PORTS];
    logic [DATA_WIDTH-1:0] st_out [STAGES][N_PORTS];
    logic [DATA_WIDTH-1:0] data_q [STAGES][N_PORTS];
    logic [SW_NUM-1:0]     stage_cfg [STAGES];
    logic [STAGES-1:0]     valid_q;
    logic [STAGES-1:0]     up_valid;
    logic                  advance;

    assign advance   = !valid_q[STAGES-1] || out_ready;
    assign in_ready  = advance;
    assign out_valid = valid_q[STAGES-1];
    assign up_valid  = {valid_q[STAGES-2:0], in_valid};

    always_comb begin
        for (int p = 0; p < N_PORTS; p++) out_data[p] = data_q[STAGES-1][p];
    end

    // NOTE: every always_comb output gets its default first, so no path leaves it unassigned (no latch).
    always_comb begin
        shadow_nxt = shadow_bank;
        if (cfg_we && (int'(cfg_stage) < STAGES)) shadow_nxt[cfg_stage] = cfg_bits;
    end

    // Commit sees shadow_nxt, so a write in the commit cycle lands in the active bank too.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_bank <= '0;
            active_bank <= '0;
        end else begin
            shadow_bank <= shadow_nxt;
            if (cfg_commit) active_bank <= shadow_nxt;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int CW = (STAGES - k) * SW_NUM;
        logic [CW-1:0] cfg_in;

        if (k == 0) begin : g_src
            assign cfg_in = active_bank;
            for (genvar p = 0; p < N_PORTS; p++) begin : g_port
                assign st_in[0][p] = in_data[p];
            end
        end else begin : g_src
            assign cfg_in = g_stage[k-1].g_keep.cfg_q;
            for (genvar p = 0; p < N_PORTS; p++) begin : g_port
                localparam int DST = link_dst(k - 1, p);
                assign st_in[k][DST] = data_q[k-1][p];
            end
        end

        assign stage_cfg[k] = cfg_in[SW_NUM-1:0];

        for (genvar j = 0; j < SW_NUM; j++) begin : g_sw
            assign st_out[k][2*j]   = stage_cfg[k][j] ? st_in[k][2*j+1] : st_in[k][2*j];
            assign st_out[k][2*j+1] = stage_cfg[k][j] ? st_in[k][2*j]   : st_in[k][2*j+1];
        end

        // The beat keeps only the settings for the stages still ahead of it.
        if (k < STAGES - 1) begin : g_keep
            logic [CW-SW_NUM-1:0] cfg_q;
            always_ff @(posedge clk) begin
                if (!rst_n)                     cfg_q <= '0;
                else if (advance && up_valid[k]) cfg_q <= cfg_in[CW-1:SW_NUM];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    // NOTE: the datapath registers are reset as well, so out_data reads 0 straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < STAGES; k++)
                for (int p = 0; p < N_PORTS; p++) data_q[k][p] <= '0;
        end else if (advance) begin
            valid_q <= up_valid;
            for (int k = 0; k < STAGES; k++)
                if (up_valid[k])
                    for (int p = 0; p < N_PORTS; p++) data_q[k][p] <= st_out[k][p];
        end
    end

endmodule

// File: tb/tb_benes_pipe_network.sv
// Directed and random-permutation bench for benes_pipe_network (8 ports, 16-bit data).
// Switch settings for random permutations come from a looping-algorithm router in the bench.
module tb_benes_pipe_network;

    localparam int N      = 8;
    localparam int DW     = 16;
    localparam int STAGES = 5;
    localparam int SW     = 4;

    typedef logic [N-1:0][DW-1:0] beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data  [0:N-1];
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data [0:N-1];
    logic          cfg_we;
    logic [2:0]    cfg_stage;
    logic [SW-1:0] cfg_bits;
    logic          cfg_commit;

    int            n_checks = 0;
    int            n_err    = 0;
    beat_t         exp_q [$];
    bit            rand_ready = 1'b0;
    logic [SW-1:0] cfg_m [STAGES];

    always #5 clk = ~clk;

    benes_pipe_network #(.N_PORTS(N), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .cfg_we     (cfg_we),
        .cfg_stage  (cfg_stage),
        .cfg_bits   (cfg_bits),
        .cfg_commit (cfg_commit)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic beat_t pack_out();
        beat_t b;
        for (int i = 0; i < N; i++) b[i] = out_data[i];
        return b;
    endfunction

    function automatic beat_t seq_beat(input logic [DW-1:0] base);
        beat_t b;
        for (int i = 0; i < N; i++) b[i] = base + DW'(i);
        return b;
    endfunction

    function automatic beat_t pair_swap(input beat_t b);
        beat_t r;
        for (int i = 0; i < N; i++) r[i] = b[i ^ 1];
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_data(input beat_t d);
        for (int i = 0; i < N; i++) in_data[i] = d[i];
    endtask

    task automatic send_beat(input beat_t d, input beat_t e);
        int   guard;
        logic acc;
        exp_q.push_back(e);
        in_valid = 1'b1;
        drive_data(d);
        guard = 0;
        acc   = 1'b0;
        while (!acc && guard < 200) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) check("accept_timeout", {127'd0, acc}, 128'd1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            tick();
            guard++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    task automatic cfg_write(input int stage, input logic [SW-1:0] bits, input logic commit);
        cfg_we     = 1'b1;
        cfg_stage  = 3'(stage);
        cfg_bits   = bits;
        cfg_commit = commit;
        tick();
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
    endtask

    // Looping algorithm, one recursion level at a time; perm[i] is the output port for input i.
    task automatic route(input int perm [N]);
        int cur  [N];
        int nxt  [N];
        int pinv [N];
        bit done [N/2];
        int n;
        int i;
        int o;
        int ob;
        cur = perm;
        nxt = perm;
        for (int s = 0; s < STAGES; s++) cfg_m[s] = '0;
        for (int lvl = 0; lvl < 2; lvl++) begin
            n = N >> lvl;
            for (int base = 0; base < N; base += n) begin
                for (int k = 0; k < n; k++) pinv[cur[base+k]] = k;
                for (int k = 0; k < N/2; k++) done[k] = 1'b0;
                for (int js = 0; js < n / 2; js++) begin
                    i = 2 * js;
                    for (int t = 0; t < n; t++) begin
                        if (done[i>>1]) break;
                        done[i>>1] = 1'b1;
                        o  = cur[base+i];
                        ob = cur[base+(i^1)];
                        // input i rides the top subnet; its switch partner takes the bottom one
                        cfg_m[lvl][base/2 + (i>>1)]            = 1'(i & 1);
                        cfg_m[STAGES-1-lvl][base/2 + (o>>1)]  = 1'(o & 1);
                        cfg_m[STAGES-1-lvl][base/2 + (ob>>1)] = 1'((ob & 1) ^ 1);
                        nxt[base + (i>>1)]         = o >> 1;
                        nxt[base + n/2 + (i>>1)]   = ob >> 1;
                        i = pinv[ob ^ 1];
                    end
                end
            end
            cur = nxt;
        end
        for (int b = 0; b < N; b += 2) cfg_m[2][b/2] = 1'(cur[b] == 1);
    endtask

    // Output monitor: every beat taken downstream must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", {127'd0, out_valid}, 128'd0);
            else                   check("beat", pack_out(), exp_q.pop_front());
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t a;
        beat_t d;
        beat_t e;
        int    perm [N];
        int    tmp;
        int    r;
        int    sent;
        logic  acc;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        cfg_we     = 1'b0;
        cfg_stage  = '0;
        cfg_bits   = '0;
        cfg_commit = 1'b0;
        drive_data('0);
        repeat (2) tick();
        rst_n = 1'b1;

        // 1: reset state and identity latency
        check("rst_out_valid", {127'd0, out_valid}, 128'd0);
        check("rst_in_ready",  {127'd0, in_ready},  128'd1);
        check("rst_out_data",  pack_out(),          128'd0);
        a = seq_beat(16'h0A00);
        exp_q.push_back(a);
        in_valid = 1'b1;
        drive_data(a);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("lat_early", {127'd0, out_valid}, 128'd0);
        tick();
        check("lat_rise",  {127'd0, out_valid}, 128'd1);
        tick();
        check("lat_fall",  {127'd0, out_valid}, 128'd0);
        drain();

        // 2: a single crossed stage at either end swaps pairs; out-of-range stage writes are ignored
        cfg_write(0, 4'hF, 1'b1);
        send_beat(seq_beat(16'h0000), pair_swap(seq_beat(16'h0000)));
        drain();
        cfg_write(0, 4'h0, 1'b0);
        cfg_write(4, 4'hF, 1'b1);
        send_beat(seq_beat(16'h0000), pair_swap(seq_beat(16'h0000)));
        drain();
        cfg_write(4, 4'h0, 1'b0);
        cfg_write(7, 4'hF, 1'b1);
        send_beat(seq_beat(16'h0100), seq_beat(16'h0100));
        drain();

        // 3: eight-beat stream with a three-cycle downstream stall
        for (int s = 0; s < 8; s++) exp_q.push_back(seq_beat(16'h3000 + 16'(s * 16)));
        sent = 0;
        for (int c = 0; c < 16; c++) begin
            in_valid = (sent < 8);
            if (sent < 8) drive_data(seq_beat(16'h3000 + 16'(sent * 16)));
            out_ready = !(c >= 7 && c <= 9);
            @(negedge clk);
            if (c <= 12) check("stall_in_ready", {127'd0, in_ready}, {127'd0, !(c >= 7 && c <= 9)});
            if (c >= 7 && c <= 10) check("stall_out_data", pack_out(), seq_beat(16'h3020));
            acc = in_valid && in_ready;
            tick();
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

        // 4: commit (with write-through of stage 0) in B's cycle only affects C
        in_valid = 1'b1;
        drive_data(seq_beat(16'h4A00));
        exp_q.push_back(seq_beat(16'h4A00));
        tick();
        drive_data(seq_beat(16'h4B00));
        exp_q.push_back(seq_beat(16'h4B00));
        cfg_we     = 1'b1;
        cfg_stage  = 3'd0;
        cfg_bits   = 4'hF;
        cfg_commit = 1'b1;
        tick();
        cfg_we     = 1'b0;
        cfg_commit = 1'b0;
        drive_data(seq_beat(16'h4C00));
        exp_q.push_back(pair_swap(seq_beat(16'h4C00)));
        tick();
        in_valid = 1'b0;
        drain();

        // 5: reset with three beats in flight drops them and restores identity routing
        in_valid = 1'b1;
        for (int s = 0; s < 3; s++) begin
            drive_data(seq_beat(16'h5000 + 16'(s * 16)));
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            check("rst_flush_valid", {127'd0, out_valid}, 128'd0);
            tick();
        end
        send_beat(seq_beat(16'h5500), seq_beat(16'h5500));
        drain();

        // 6: random permutations routed by the looping algorithm, random downstream ready
        rand_ready = 1'b1;
        for (int t = 0; t < 500; t++) begin
            for (int k = 0; k < N; k++) perm[k] = k;
            for (int k = N - 1; k > 0; k--) begin
                r       = int'($urandom_range(0, k));
                tmp     = perm[k];
                perm[k] = perm[r];
                perm[r] = tmp;
            end
            route(perm);
            for (int s = 0; s < STAGES; s++) cfg_write(s, cfg_m[s], s == STAGES - 1);
            for (int k = 0; k < N; k++) begin
                d[k]       = 16'($urandom);
                e[perm[k]] = d[k];
            end
            send_beat(d, e);
        end
        drain();
        rand_ready = 1'b0;
        out_ready  = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
